// File: rtl/output_sram_wr_ctrl_pkg.sv
// output_sram_wr_ctrl_pkg: shared geometry, bank write-back packet and FSM state type
package output_sram_wr_ctrl_pkg;

    localparam int NUM_FV_LINE      = 4;
    localparam int FV_SIZE          = 16;
    localparam int MAX_FV_NUM       = 16;
    localparam int MAX_NODE_ID      = 64;
    localparam int LINE_W           = NUM_FV_LINE * FV_SIZE;
    localparam int LINES_PER_NODE_D = MAX_FV_NUM / NUM_FV_LINE;
    localparam int NODE_W           = $clog2(MAX_NODE_ID);
    localparam int SRAM_ADDR_W      = $clog2(MAX_NODE_ID * LINES_PER_NODE_D);

    // One bank's request/stream toward the output SRAM.
    typedef struct packed {
        logic              req;
        logic              grant_valid;
        logic              sos;
        logic              eos;
        logic [NODE_W-1:0] node_id;
        logic [LINE_W-1:0] data;
    } bank_pkt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RECV  = 2'd2,
        DONE  = 2'd3
    } owsr_state_t;

endpackage

// File: rtl/output_sram_wr_ctrl_rr_arbiter.sv
// output_sram_wr_ctrl_rr_arbiter: combinational round-robin pick of the first requester at/after ptr
module output_sram_wr_ctrl_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] win,
    output logic          any
);

    int k;

    // Scan from ptr upward with wrap; first hit wins.
    always_comb begin
        grant = '0;
        win   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any && req[k]) begin
                grant[k] = 1'b1;
                win      = PW'(k);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_sram_wr_ctrl.sv
// output_sram_wr_ctrl: arbitrates bank write-back streams and writes lines to the output SRAM (OUT_SRAM_PROTO_CHK_EN enables proto_err)
module output_sram_wr_ctrl
    import output_sram_wr_ctrl_pkg::*;
#(
    parameter int NUM_BANKS      = 4,
    parameter int DATA_W         = LINE_W,
    parameter int LINES_PER_NODE = LINES_PER_NODE_D,
    parameter int NODE_ID_W      = NODE_W,
    parameter int ADDR_W         = SRAM_ADDR_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  bank_pkt_t [NUM_BANKS-1:0]       bank_pkt,
    output logic      [NUM_BANKS-1:0]       req_grant,
    output logic                            sram_wen,
    output logic      [ADDR_W-1:0]          sram_addr,
    output logic      [DATA_W-1:0]          sram_wdata,
    output logic                            wr_done,
    output logic      [NODE_ID_W-1:0]       wr_node_id,
    output logic                            busy,
    output logic                            proto_err
);

    localparam int PW    = $clog2(NUM_BANKS);
    localparam int CNT_W = $clog2(LINES_PER_NODE + 1);

    owsr_state_t          state, state_d;
    logic [PW-1:0]        owner, owner_d, rr_ptr, rr_ptr_d, win;
    logic [NUM_BANKS-1:0] req_vec, win_oh, grant_d;
    logic                 any_req;
    logic [NODE_ID_W-1:0] node, node_d, wr_node_id_d;
    logic [CNT_W-1:0]     line_cnt, line_cnt_d, idx;
    logic                 cap, cap_ok;
    logic                 own_gv, own_sos, own_eos;
    logic [NODE_ID_W-1:0] own_node;
    logic [DATA_W-1:0]    own_data, wdata_d;
    logic [ADDR_W-1:0]    addr_d;

    // Gather request bits for the arbiter.
    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_BANKS; i++) req_vec[i] = bank_pkt[i].req;
    end

    assign own_gv   = bank_pkt[owner].grant_valid;
    assign own_sos  = bank_pkt[owner].sos;
    assign own_eos  = bank_pkt[owner].eos;
    assign own_node = bank_pkt[owner].node_id;
    assign own_data = bank_pkt[owner].data;

    output_sram_wr_ctrl_rr_arbiter #(.N(NUM_BANKS), .PW(PW)) u_arb (
        .req   (req_vec),
        .ptr   (rr_ptr),
        .grant (win_oh),
        .win   (win),
        .any   (any_req)
    );

    // Next state, owner latch, grant and round-robin pointer advance.
    always_comb begin
        state_d  = state;
        owner_d  = owner;
        rr_ptr_d = rr_ptr;
        node_d   = node;
        grant_d  = '0;
        cap      = 1'b0;
        case (state)
            IDLE: if (any_req) begin
                owner_d = win;
                grant_d = win_oh;
                state_d = GRANT;
            end
            GRANT: if (own_gv && own_sos) begin
                cap     = 1'b1;
                node_d  = own_node;
                state_d = own_eos ? DONE : RECV;
            end else begin
                state_d = IDLE;
            end
            RECV: if (own_gv) begin
                cap     = 1'b1;
                state_d = own_eos ? DONE : RECV;
            end
            DONE: begin
                rr_ptr_d = (int'(owner) == NUM_BANKS - 1) ? '0 : owner + PW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line index, overrun drop and next values of the registered write port.
    always_comb begin
        idx          = (state == GRANT) ? '0 : line_cnt;
        cap_ok       = cap && (int'(idx) < LINES_PER_NODE);
        line_cnt_d   = cap_ok ? idx + CNT_W'(1) : (cap ? idx : line_cnt);
        addr_d       = cap_ok ? ADDR_W'(int'(node_d) * LINES_PER_NODE + int'(idx)) : sram_addr;
        wdata_d      = cap_ok ? own_data : sram_wdata;
        wr_node_id_d = (state_d == DONE) ? node_d : wr_node_id;
    end

    // State and all outputs are registered; reset aborts any stream in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            node       <= '0;
            line_cnt   <= '0;
            req_grant  <= '0;
            sram_wen   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            wr_done    <= 1'b0;
            wr_node_id <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            rr_ptr     <= rr_ptr_d;
            node       <= node_d;
            line_cnt   <= line_cnt_d;
            req_grant  <= grant_d;
            sram_wen   <= cap_ok;
            sram_addr  <= addr_d;
            sram_wdata <= wdata_d;
            wr_done    <= (state_d == DONE);
            wr_node_id <= wr_node_id_d;
            busy       <= (state_d != IDLE);
        end
    end

`ifdef OUT_SRAM_PROTO_CHK_EN
    logic err;

    // Protocol violations: bad grant response, sos/gap/id change mid-stream, overrun.
    always_comb begin
        err = ((state == GRANT) && !(own_gv && own_sos)) ||
              ((state == RECV) && (!own_gv || own_sos || (own_node != node))) ||
              (cap && !cap_ok);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) proto_err <= 1'b0;
        else        proto_err <= proto_err | err;
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_sram_wr_ctrl.sv
// tb_output_sram_wr_ctrl: randomized bank streams checked every cycle against a stream-level model
module tb_output_sram_wr_ctrl;
    import output_sram_wr_ctrl_pkg::*;

    localparam int NB  = 4;
    localparam int LPN = LINES_PER_NODE_D;
`ifdef OUT_SRAM_PROTO_CHK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    bank_pkt_t [NB-1:0]     bank_pkt;
    logic [NB-1:0]          req_grant;
    logic                   sram_wen;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [LINE_W-1:0]      sram_wdata;
    logic                   wr_done;
    logic [NODE_W-1:0]      wr_node_id;
    logic                   busy;
    logic                   proto_err;

    always #5 clk = ~clk;

    output_sram_wr_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .bank_pkt   (bank_pkt),
        .req_grant  (req_grant),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .wr_done    (wr_done),
        .wr_node_id (wr_node_id),
        .busy       (busy),
        .proto_err  (proto_err)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t         q[$];
    int          tests = 0, fails = 0, cyc = 0;
    bit          p_valid[NB], p_mute[NB];
    int          p_node[NB], p_len[NB];
    logic [63:0] p_data[NB][8];
    logic [NB-1:0] req_drv;
    bit          m_idle, in_stream, s_on;
    int          s_bank, s_k, ptr, exp_done_cyc, exp_done_node, err_cyc;
    int          grant_log[$];
    int          wr_count, first_addr, last_addr, done_node, done_cyc, grant_cyc;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic seterr(int c);
`ifdef OUT_SRAM_PROTO_CHK_EN
        if (c < err_cyc) err_cyc = c;
`endif
    endtask

    task automatic clear_logs();
        grant_log.delete();
        wr_count = 0; first_addr = -1; last_addr = -1;
        done_node = -1; done_cyc = -1; grant_cyc = -1;
    endtask

    function automatic bit quiet();
        bit any = 1'b0;
        for (int i = 0; i < NB; i++) any |= p_valid[i];
        return !any && !s_on && !in_stream && q.size() == 0;
    endfunction

    task automatic add(int b, int node, int len, bit mute);
        p_valid[b] = 1'b1;
        p_mute[b]  = mute;
        p_node[b]  = node;
        p_len[b]   = len;
        for (int k = 0; k < 8; k++) p_data[b][k] = {$urandom, $urandom};
    endtask

    // Assert reset between edges, check outputs cleared at once, then restart the model.
    task automatic apply_reset();
        #2 reset = 1'b0;
        bank_pkt = '0;
        #1;
        chk("rst_req_grant", req_grant, 0);
        chk("rst_sram_wen", sram_wen, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_wr_node_id", wr_node_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_proto_err", proto_err, 0);
        q.delete();
        for (int i = 0; i < NB; i++) p_valid[i] = 1'b0;
        req_drv = '0; m_idle = 1'b1; in_stream = 1'b0; s_on = 1'b0;
        ptr = 0; exp_done_cyc = -1; err_cyc = 1 << 30;
        clear_logs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One cycle: check DUT against the model, advance the model, drive the banks.
    task automatic step();
        logic [NB-1:0] eg;
        bit bz, gap, exp_wen;
        int w, b;
        @(negedge clk);
        cyc++;
        eg = '0;
        if (m_idle)
            for (int i = 0; i < NB; i++) begin
                w = (ptr + i) % NB;
                if (eg == 0 && req_drv[w]) eg[w] = 1'b1;
            end
        bz = (eg != 0) || in_stream;
        for (int i = 0; i < NB; i++) if (req_grant[i]) grant_log.push_back(i);
        if (req_grant != 0) grant_cyc = cyc;
        if (sram_wen) begin
            if (wr_count == 0) first_addr = int'(sram_addr);
            last_addr = int'(sram_addr);
            wr_count++;
        end
        if (wr_done) begin done_node = int'(wr_node_id); done_cyc = cyc; end
        chk("req_grant", req_grant, eg);
        chk("busy", busy, bz);
        exp_wen = q.size() > 0 && q[0].cyc == cyc;
        chk("sram_wen", sram_wen, exp_wen);
        if (exp_wen) begin
            chk("sram_addr", sram_addr, q[0].addr);
            chk("sram_wdata", sram_wdata, q[0].data);
            void'(q.pop_front());
        end
        chk("wr_done", wr_done, cyc == exp_done_cyc);
        if (cyc == exp_done_cyc) begin
            chk("wr_node_id", wr_node_id, exp_done_node);
            in_stream = 1'b0;
            ptr = (s_bank + 1) % NB;
        end
        chk("proto_err", proto_err, cyc >= err_cyc);
        m_idle = !bz;
        for (int i = 0; i < NB; i++)
            if (eg[i]) begin
                p_valid[i] = 1'b0;
                if (p_mute[i]) seterr(cyc + 1);
                else begin
                    s_on = 1'b1; s_bank = i; s_k = 0; in_stream = 1'b1;
                end
            end
        for (int i = 0; i < NB; i++) begin
            req_drv[i] = p_valid[i];
            bank_pkt[i] = '0;
            bank_pkt[i].req = p_valid[i];
            bank_pkt[i].node_id = NODE_W'($urandom);
            bank_pkt[i].data = {$urandom, $urandom};
        end
        if (s_on) begin
            gap = 1'b0;
`ifndef OUT_SRAM_PROTO_CHK_EN
            if (s_k > 0 && $urandom_range(0, 3) == 0) gap = 1'b1;
`endif
            if (!gap) begin
                b = s_bank;
                bank_pkt[b].grant_valid = 1'b1;
                bank_pkt[b].sos = (s_k == 0);
                bank_pkt[b].eos = (s_k == p_len[b] - 1);
                bank_pkt[b].node_id = NODE_W'(p_node[b]);
                bank_pkt[b].data = p_data[b][s_k];
                if (s_k < LPN) q.push_back('{cyc + 1, 8'(p_node[b] * LPN + s_k), p_data[b][s_k]});
                else seterr(cyc + 1);
                if (s_k == p_len[b] - 1) begin
                    exp_done_cyc = cyc + 1;
                    exp_done_node = p_node[b];
                    s_on = 1'b0;
                end
                s_k++;
            end
        end
    endtask

    task automatic run_quiet(int limit);
        int n = 0;
        step();
        while (!quiet() && n < limit) begin step(); n++; end
        if (n >= limit) begin
            tests++; fails++;
            $display("FAIL timeout: stream not finished after %0d cycles (cycle %0d)", limit, cyc);
        end
        step();
        step();
    endtask

    initial begin
        bank_pkt = '0;
        apply_reset();

        // 1: bank1, node 5, four lines
        add(1, 5, 4, 1'b0);
        run_quiet(100);
        chk("t1_grants", grant_log.size(), 1);
        if (grant_log.size() > 0) chk("t1_grant_bank", grant_log[0], 1);
        chk("t1_writes", wr_count, 4);
        chk("t1_first_addr", first_addr, 20);
        chk("t1_last_addr", last_addr, 23);
        chk("t1_done_node", done_node, 5);

        // 2: all banks at once from reset, two rounds
        apply_reset();
        for (int b = 0; b < NB; b++) add(b, 10 + b, 1 + b, 1'b0);
        run_quiet(200);
        chk("t2_grants", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++) chk("t2_order", grant_log[i], i);
        clear_logs();
        for (int b = 0; b < NB; b++) add(b, 30 + b, 3, 1'b0);
        run_quiet(200);
        chk("t2_round2_grants", grant_log.size(), 4);
        if (grant_log.size() > 0) chk("t2_round2_first", grant_log[0], 0);

        // 3: single-line stream, node 2
        apply_reset();
        add(0, 2, 1, 1'b0);
        run_quiet(100);
        chk("t3_writes", wr_count, 1);
        chk("t3_addr", first_addr, 8);
        chk("t3_done_lat", done_cyc - grant_cyc, 1);

        // 4: six-line stream overruns four slots
        clear_logs();
        add(2, 9, 6, 1'b0);
        run_quiet(100);
        chk("t4_writes", wr_count, 4);
        chk("t4_last_addr", last_addr, 39);
        chk("t4_proto_err", proto_err, EXP_ERR);

        // 6: grant never answered
        apply_reset();
        add(3, 4, 3, 1'b1);
        run_quiet(100);
        chk("t6_grants", grant_log.size(), 1);
        chk("t6_writes", wr_count, 0);
        chk("t6_proto_err", proto_err, EXP_ERR);

        // 5: reset during RECV line 2, then a fresh request
        apply_reset();
        add(2, 7, 5, 1'b0);
        for (int n = 0; n < 50 && !(s_on && s_k == 3); n++) step();
        apply_reset();
        add(3, 1, 2, 1'b0);
        run_quiet(100);
        chk("t5_writes", wr_count, 2);
        chk("t5_first_addr", first_addr, 4);
        if (grant_log.size() > 0) chk("t5_grant_bank", grant_log[0], 3);

        // random rounds
        apply_reset();
        for (int r = 0; r < 25; r++) begin
            int mask;
            mask = $urandom_range(1, 15);
            for (int b = 0; b < NB; b++)
                if (mask[b]) add(b, $urandom_range(0, MAX_NODE_ID - 1), $urandom_range(1, 6), $urandom_range(0, 7) == 0);
            run_quiet(400);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
